data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between a datapath (master) and its data memory
// responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, serviced from a word array after WAIT_CYCLES
// wait states. Define DMEM_STATS_EN to add load/store counters.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clock,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]         load_count,
  output logic [31:0]         store_count
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        accept, exec;

  logic [31:0] mem [DEPTH];

  // The access executes on the edge entering RESP; with no wait states that is the
  // acceptance edge itself, so the live request is used instead of the captured one.
  logic [31:0]   acc_addr, acc_wdata;
  logic          acc_write, acc_err;
  logic [IW-1:0] acc_idx;

  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_write = bus.req_write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = write_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IW + 2)) != 32'd0);
    acc_idx = acc_addr[IW+1:2];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    error_d       = error_q;
    accept        = 1'b0;
    exec          = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = reset_n;
        if (bus.req_valid && reset_n) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            exec    = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
          rdata_d = 32'd0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (exec) begin
      error_d = acc_err;
      rdata_d = (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (exec && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_count  <= 32'd0;
      store_count <= 32'd0;
    end else if (exec && !acc_err) begin
      if (acc_write) begin
        store_count <= store_count + 32'd1;
      end else begin
        load_count <= load_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level model, plus directed transactions with literal expectations.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();

`ifdef DMEM_STATS_EN
  logic [31:0] lc_a, sc_a, lc_b, sc_b;
`endif

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
`ifdef DMEM_STATS_EN
    , .load_count(lc_a), .store_count(sc_a)
`endif
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b)
`ifdef DMEM_STATS_EN
    , .load_count(lc_b), .store_count(sc_b)
`endif
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {req_ready, rsp_valid, rsp_error, rsp_rdata}
  function automatic logic [34:0] sample(input int d);
    if (d == 0) return {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_error, bus_a.rsp_rdata};
    return {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_error, bus_b.rsp_rdata};
  endfunction

  task automatic drive_req(input int d, input logic v, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd);
    if (d == 0) begin
      bus_a.req_valid = v; bus_a.req_write = wr; bus_a.req_addr = addr; bus_a.req_wdata = wd;
    end else begin
      bus_b.req_valid = v; bus_b.req_write = wr; bus_b.req_addr = addr; bus_b.req_wdata = wd;
    end
  endtask

  task automatic drive_rdy(input int d, input logic r);
    if (d == 0) bus_a.rsp_ready = r;
    else bus_b.rsp_ready = r;
  endtask

  // Transaction-level model: one outstanding request per instance.
  bit          busy_m [2];
  bit          resp_m [2];
  int          rem_m  [2];
  logic [31:0] cap_addr [2];
  logic [31:0] cap_wd   [2];
  bit          cap_wr   [2];
  logic [31:0] exp_rd   [2];
  bit          exp_err  [2];
  logic [31:0] mem_m    [2][DEPTH];
  int          ld_m     [2];
  int          st_m     [2];

  task automatic model_exec(input int d);
    bit err;
    int idx;
    err = (cap_addr[d][1:0] != 2'b00) || (cap_addr[d] >= DEPTH * 4);
    idx = int'(cap_addr[d] >> 2);
    exp_err[d] = err;
    exp_rd[d]  = 32'd0;
    if (!err && cap_wr[d]) begin
      mem_m[d][idx] = cap_wd[d];
      st_m[d]++;
    end else if (!err) begin
      exp_rd[d] = mem_m[d][idx];
      ld_m[d]++;
    end
    busy_m[d] = 1'b0;
    resp_m[d] = 1'b1;
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin : per_dut
      logic [34:0] s;
      logic        rv, rw, rr;
      logic [31:0] ra, rwd;
      string       nm;
      nm = (d == 0) ? "a" : "b";
      s  = sample(d);
      if (d == 0) begin
        rv = bus_a.req_valid; rw = bus_a.req_write; rr = bus_a.rsp_ready;
        ra = bus_a.req_addr;  rwd = bus_a.req_wdata;
      end else begin
        rv = bus_b.req_valid; rw = bus_b.req_write; rr = bus_b.rsp_ready;
        ra = bus_b.req_addr;  rwd = bus_b.req_wdata;
      end
      if (!reset_n) begin
        busy_m[d] = 1'b0; resp_m[d] = 1'b0; exp_rd[d] = 32'd0; exp_err[d] = 1'b0;
        ld_m[d] = 0; st_m[d] = 0;
      end
      check({nm, ".req_ready"}, 64'(s[34]), 64'(reset_n && !busy_m[d] && !resp_m[d]));
      check({nm, ".rsp_valid"}, 64'(s[33]), 64'(resp_m[d]));
      check({nm, ".rsp_error"}, 64'(s[32]), 64'(exp_err[d]));
      check({nm, ".rsp_rdata"}, 64'(s[31:0]), 64'(exp_rd[d]));
`ifdef DMEM_STATS_EN
      check({nm, ".load_count"}, 64'((d == 0) ? lc_a : lc_b), 64'(ld_m[d]));
      check({nm, ".store_count"}, 64'((d == 0) ? sc_a : sc_b), 64'(st_m[d]));
`endif
      // Predict the coming rising edge.
      if (reset_n) begin
        if (resp_m[d]) begin
          if (rr) begin
            resp_m[d] = 1'b0; exp_rd[d] = 32'd0; exp_err[d] = 1'b0;
          end
        end else if (busy_m[d]) begin
          rem_m[d]--;
          if (rem_m[d] == 0) model_exec(d);
        end else if (rv) begin
          cap_addr[d] = ra; cap_wd[d] = rwd; cap_wr[d] = rw;
          if (wait_of(d) == 0) model_exec(d);
          else begin
            busy_m[d] = 1'b1;
            rem_m[d]  = wait_of(d);
          end
        end
      end
    end
  end

  // One request with literal expectations; hold = cycles to keep rsp_ready low in RESP.
  task automatic txn(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input logic err, input int lat, input int hold);
    logic [34:0] s;
    int          k;
    drive_req(d, 1'b1, wr, addr, wd);
    @(posedge clock); #1;
    drive_req(d, 1'b0, 1'b0, 32'd0, 32'd0);
    k = 1;
    s = sample(d);
    while (!s[33] && k < 40) begin
      @(posedge clock); #1;
      k++;
      s = sample(d);
    end
    check("latency", 64'(k), 64'(lat));
    check("rsp_rdata", 64'(s[31:0]), 64'(rd));
    check("rsp_error", 64'(s[32]), 64'(err));
    repeat (hold) begin
      @(posedge clock); #1;
      s = sample(d);
      check("held_rsp", 64'(s), 64'({2'b01, err, rd}));
    end
    drive_rdy(d, 1'b1);
    @(posedge clock); #1;
    drive_rdy(d, 1'b0);
    check("after_handshake", 64'(sample(d)), 64'({1'b1, 34'd0}));
  endtask

  initial begin
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_rdy(0, 1'b0);
    drive_rdy(1, 1'b0);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_a", 64'(sample(0)), 64'd0);
    check("reset_b", 64'(sample(1)), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Store then load, misaligned and out-of-range accesses, stalled response.
    txn(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3, 0);
    txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 0);
    txn(0, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 3, 0);
    txn(0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 3, 0);
    txn(0, 1'b1, 32'h404, 32'hFFFFFFFF, 32'h0,        1'b1, 3, 0);
    txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 5);

    // Reset while a store waits: it must never land.
    txn(0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 3, 0);
    drive_req(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_a", 64'(sample(0)), 64'd0);
    check("midreset_b", 64'(sample(1)), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3, 0);

    // Zero wait states, boundary words.
    txn(1, 1'b1, 32'h0,   32'hA5A50001, 32'h0,        1'b0, 1, 0);
    txn(1, 1'b1, 32'h3FC, 32'h5A5AFFFE, 32'h0,        1'b0, 1, 0);
    txn(1, 1'b0, 32'h0,   32'h0,        32'hA5A50001, 1'b0, 1, 0);
    txn(1, 1'b0, 32'h3FC, 32'h0,        32'h5A5AFFFE, 1'b0, 1, 2);
    txn(1, 1'b0, 32'h2,   32'h0,        32'h0,        1'b1, 1, 0);
    txn(1, 1'b0, 32'h0,   32'h0,        32'hA5A50001, 1'b0, 1, 0);

`ifdef DMEM_STATS_EN
    check("lit_load_count_b", 64'(lc_b), 64'd3);
    check("lit_store_count_b", 64'(sc_b), 64'd2);
    check("lit_load_count_a", 64'(lc_a), 64'd1);
    check("lit_store_count_a", 64'(sc_a), 64'd0);
`endif

    repeat (2) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
